// File: rtl/mips_data_bus.sv
// mips_data_bus
//   Data-side memory/MMIO subsystem for the multicycle MIPS core. Each word
//   address from the core's data port is decoded into one of three regions:
//     - on-chip data RAM (RAM_WORDS x 32), at addresses below RAM_WORDS*4
//     - a small peripheral block in the 256-byte window at MMIO_BASE
//     - unmapped (reads return 0; writes are dropped and raise bus_err)
//   Reads are registered: data_rd carries the value addressed on the
//   previous cycle. The core does not provide a read enable.
//
//   Peripheral map (word offsets within the MMIO window):
//     0x00 GPIO_OUT   RW, zero-extended on read
//     0x04 GPIO_IN    RO, 2-flop synchronized copy of gpio_in
//     0x08 TIMER_CNT  RW, free-running counter while EN=1
//     0x0C TIMER_CMP  RW, compare value
//     0x10 TIMER_CTRL RW, bit0 EN, bit1 AUTOCLR, bit2 FLAG (write 1 to clear)
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   data_addr   byte address from core; bits [1:0] ignored
//   data_wr     store data
//   data_wr_en  store strobe, one cycle per store
//   data_rd     registered read data
//   gpio_in     asynchronous external inputs
//   gpio_out    GPIO output register
//   timer_irq   timer match flag (level)
//   bus_err     one-cycle pulse after a store to an unmapped or RO location
module mips_data_bus #(
  parameter int          RAM_WORDS = 1024,
  parameter int          GPIO_W    = 16,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wr,
  input  logic              data_wr_en,
  output logic [31:0]       data_rd,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  // 33 bits so a 4 GiB-sized RAM parameter cannot overflow the compare.
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  typedef enum logic [2:0] {
    REG_GPIO_OUT,
    REG_GPIO_IN,
    REG_TIMER_CNT,
    REG_TIMER_CMP,
    REG_TIMER_CTRL,
    REG_NONE
  } mmio_reg_e;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic          is_ram;
  logic          is_mmio;
  logic          unmapped;
  mmio_reg_e     reg_sel;
  logic [AW-1:0] ram_idx;

  always_comb begin
    is_ram  = ({1'b0, data_addr} < RAM_BYTES);
    // RAM takes precedence should a parameter choice ever overlap the two.
    is_mmio = !is_ram && (data_addr[31:8] == MMIO_BASE[31:8]);
    reg_sel = REG_NONE;
    if (is_mmio) begin
      case (data_addr[7:2])
        6'd0:    reg_sel = REG_GPIO_OUT;
        6'd1:    reg_sel = REG_GPIO_IN;
        6'd2:    reg_sel = REG_TIMER_CNT;
        6'd3:    reg_sel = REG_TIMER_CMP;
        6'd4:    reg_sel = REG_TIMER_CTRL;
        default: reg_sel = REG_NONE;
      endcase
    end
    unmapped = !is_ram && (reg_sel == REG_NONE);
    ram_idx  = data_addr[AW+1:2];
  end

  // ---------------------------------------------------------------------
  // Data RAM: read-first, no reset on contents. Stores are gated by rst_n
  // so a store issued while the core is held in reset is dropped.
  // ---------------------------------------------------------------------
  logic [31:0] mem [RAM_WORDS];
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (rst_n && data_wr_en && is_ram) begin
      mem[ram_idx] <= data_wr;
    end
    ram_q <= mem[ram_idx];
  end

  // ---------------------------------------------------------------------
  // Peripheral registers
  // ---------------------------------------------------------------------
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_s1_q, gpio_s2_q;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              en_q, en_d;
  logic              aclr_q, aclr_d;
  logic              flag_q, flag_d;
  logic              wr_gpio, wr_cnt, wr_cmp, wr_ctrl;
  logic              match;

  always_comb begin
    wr_gpio = data_wr_en && (reg_sel == REG_GPIO_OUT);
    wr_cnt  = data_wr_en && (reg_sel == REG_TIMER_CNT);
    wr_cmp  = data_wr_en && (reg_sel == REG_TIMER_CMP);
    wr_ctrl = data_wr_en && (reg_sel == REG_TIMER_CTRL);
    match   = en_q && (cnt_q == cmp_q);

    gpio_out_d = wr_gpio ? data_wr[GPIO_W-1:0] : gpio_out_q;
    cmp_d      = wr_cmp  ? data_wr : cmp_q;
    en_d       = wr_ctrl ? data_wr[0] : en_q;
    aclr_d     = wr_ctrl ? data_wr[1] : aclr_q;

    // Counter: increment / auto-clear, overridden by a software store.
    cnt_d = cnt_q;
    if (en_q) begin
      cnt_d = (match && aclr_q) ? 32'd0 : cnt_q + 32'd1;
    end
    if (wr_cnt) begin
      cnt_d = data_wr;
    end

    // FLAG: write-1-to-clear, but a match in the same cycle wins so an
    // event is never lost to a racing acknowledge.
    flag_d = flag_q;
    if (wr_ctrl && data_wr[2]) begin
      flag_d = 1'b0;
    end
    if (match) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
      cnt_q      <= '0;
      cmp_q      <= '0;
      en_q       <= 1'b0;
      aclr_q     <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      gpio_s1_q  <= gpio_in;
      gpio_s2_q  <= gpio_s1_q;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      en_q       <= en_d;
      aclr_q     <= aclr_d;
      flag_q     <= flag_d;
    end
  end

  // ---------------------------------------------------------------------
  // Read path. MMIO values are sampled from the current register state,
  // which gives read-first behaviour and the pre-increment counter value.
  // The RAM word is registered separately and selected at the output.
  // ---------------------------------------------------------------------
  logic [31:0] mmio_rd_d, mmio_rd_q;
  logic        sel_ram_q;
  logic        bus_err_d, bus_err_q;

  always_comb begin
    mmio_rd_d = 32'd0;
    case (reg_sel)
      REG_GPIO_OUT:   mmio_rd_d = 32'(gpio_out_q);
      REG_GPIO_IN:    mmio_rd_d = 32'(gpio_s2_q);
      REG_TIMER_CNT:  mmio_rd_d = cnt_q;
      REG_TIMER_CMP:  mmio_rd_d = cmp_q;
      REG_TIMER_CTRL: mmio_rd_d = {29'd0, flag_q, aclr_q, en_q};
      default:        mmio_rd_d = 32'd0;
    endcase
    // Only stores fault: the core presents an address every cycle.
    bus_err_d = data_wr_en && (unmapped || (reg_sel == REG_GPIO_IN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mmio_rd_q <= '0;
      sel_ram_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      mmio_rd_q <= mmio_rd_d;
      sel_ram_q <= is_ram;
      bus_err_q <= bus_err_d;
    end
  end

  assign data_rd   = sel_ram_q ? ram_q : mmio_rd_q;
  assign gpio_out  = gpio_out_q;
  assign timer_irq = flag_q;
  assign bus_err   = bus_err_q;

endmodule
